// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving one-hot-or-zero tristate output enables.
// Every new grant is preceded by an all-off turnaround gap.
module tristate_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         oe,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     preempt
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [3:0] LP_TURN = 4'(TURNAROUND);
  localparam logic [7:0] LP_HOLD = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_OWN
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_oe;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_ptr;
  logic             r_busy;
  logic             r_preempt;
  logic [3:0]       r_turn;
  logic [7:0]       r_hold;

  logic [IW-1:0]    w_nxt;
  logic [IW:0]      w_arb_p;
  logic [IW:0]      w_arb_n;
  logic             w_others;
  logic             w_pre;

  // First requester at or after base, wrapping; MSB flags a hit.
  function automatic logic [IW:0] f_arb(
    input logic [N_REQ-1:0] r,
    input logic [IW-1:0]    base
  );
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(base) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (r[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  // Next pointer after the owner, arbitration candidates, preempt test.
  always_comb begin
    w_nxt = r_owner + 1'b1;
    if (r_owner == IW'(N_REQ - 1)) w_nxt = '0;
    w_arb_p  = f_arb(req, r_ptr);
    w_arb_n  = f_arb(req, w_nxt);
    w_others = |(req & ~(N_REQ'(1) << r_owner));
    w_pre    = (LP_HOLD != 8'd0) && (r_hold == LP_HOLD) && w_others;
  end

  // Arbitration FSM with registered enables and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_oe      <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
      r_turn    <= '0;
      r_hold    <= '0;
    end else begin
      r_preempt <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_arb_p[IW]) begin
            r_owner <= w_arb_p[IW-1:0];
            r_turn  <= LP_TURN;
            r_busy  <= 1'b1;
            r_state <= S_TURN;
          end
        end
        S_TURN: begin
          if (r_turn > 4'd1) begin
            r_turn <= r_turn - 4'd1;
          end else if (req[r_owner]) begin
            r_oe    <= N_REQ'(1) << r_owner;
            r_hold  <= 8'd1;
            r_state <= S_OWN;
          end else if (w_arb_p[IW]) begin
            r_owner <= w_arb_p[IW-1:0];
            r_turn  <= LP_TURN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (!req[r_owner] || w_pre) begin
            // A plain release wins over a coincident preempt.
            r_oe      <= '0;
            r_ptr     <= w_nxt;
            r_preempt <= req[r_owner];
            if (w_arb_n[IW]) begin
              r_owner <= w_arb_n[IW-1:0];
              r_turn  <= LP_TURN;
              r_state <= S_TURN;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (LP_HOLD != 8'd0 && r_hold == LP_HOLD) begin
            r_hold <= 8'd1;
          end else if (r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_oe    <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oe      = r_oe;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter.
// Second instance runs with preemption disabled on the same inputs.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] oe, oe2;
  logic [1:0] owner, owner2;
  logic       busy, busy2;
  logic       pre, pre2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(
    .N_REQ(4), .TURNAROUND(1), .MAX_HOLD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .oe(oe), .owner(owner), .busy(busy), .preempt(pre)
  );

  tristate_bus_arbiter #(
    .N_REQ(4), .TURNAROUND(1), .MAX_HOLD(0)
  ) dut_nopre (
    .clk(clk), .rst_n(rst_n), .req(req),
    .oe(oe2), .owner(owner2), .busy(busy2), .preempt(pre2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    repeat (3) tick();
    n_vec++;
    if (oe !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_oe: got %b want 0000", oe);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_vec++;
    if (owner !== 2'd0) begin
      n_err++;
      $display("FAIL reset_owner: got %0d want 0", owner);
    end
    n_vec++;
    if (pre !== 1'b0) begin
      n_err++;
      $display("FAIL reset_preempt: got %b want 0", pre);
    end
    rst_n = 1'b1;
    req = 4'b0100;
    tick();
    tick();
    n_vec++;
    if (oe !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_pre_own: got %b want 0100", oe);
    end
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (oe !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_own: got oe=%b busy=%b want 0000/0",
               oe, busy);
    end
    rst_n = 1'b1;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    tick();
    n_vec++;
    if (busy !== 1'b1 || oe !== 4'b0000) begin
      n_err++;
      $display("FAIL single_e0: got busy=%b oe=%b want 1/0000",
               busy, oe);
    end
    tick();
    n_vec++;
    if (oe !== 4'b0010 || owner !== 2'd1) begin
      n_err++;
      $display("FAIL single_e1: got oe=%b owner=%0d want 0010/1",
               oe, owner);
    end
    repeat (3) tick();
    n_vec++;
    if (oe !== 4'b0010) begin
      n_err++;
      $display("FAIL single_e4: got oe=%b want 0010", oe);
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (oe !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_rel: got oe=%b busy=%b want 0000/0",
               oe, busy);
    end
  endtask

  task automatic test_round_robin();
    int         exp_own [4];
    int         grants;
    int         held;
    int         zeros;
    int         drop_k;
    logic [3:0] prev;
    exp_own = '{0, 1, 3, 0};
    grants = 0;
    held = 0;
    zeros = 0;
    drop_k = -1;
    prev = 4'b0000;
    do_reset();
    req = 4'b1011;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      tick();
      n_vec++;
      if ($countones(oe) > 1) begin
        n_err++;
        $display("FAIL rr_onehot: got oe=%b want <=1 bit", oe);
      end
      if (drop_k >= 0) begin
        req[drop_k] = 1'b1;
        drop_k = -1;
      end
      if (oe == 4'b0000) begin
        zeros++;
        held = 0;
      end else begin
        if (prev == 4'b0000) begin
          n_vec++;
          if (owner !== 2'(exp_own[grants]) ||
              oe !== (4'b0001 << exp_own[grants])) begin
            n_err++;
            $display("FAIL rr_order%0d: got owner=%0d oe=%b want %0d",
                     grants, owner, oe, exp_own[grants]);
          end
          if (grants > 0) begin
            n_vec++;
            if (zeros != 1) begin
              n_err++;
              $display("FAIL rr_gap%0d: got %0d idle want 1",
                       grants, zeros);
            end
          end
          grants++;
          zeros = 0;
          held = 0;
        end
        held++;
        if (held == 3) begin
          drop_k = int'(owner);
          req[drop_k] = 1'b0;
        end
      end
      prev = oe;
    end
    n_vec++;
    if (grants != 4) begin
      n_err++;
      $display("FAIL rr_timeout: got %0d grants want 4", grants);
    end
    req = 4'b0000;
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0101;
    for (int k = 2; k <= 8; k++) begin
      tick();
      n_vec++;
      if (oe !== 4'b0100 || pre !== 1'b0) begin
        n_err++;
        $display("FAIL pre_hold%0d: got oe=%b pre=%b want 0100/0",
                 k, oe, pre);
      end
    end
    tick();
    n_vec++;
    if (pre !== 1'b1 || oe !== 4'b0000) begin
      n_err++;
      $display("FAIL pre_pulse: got pre=%b oe=%b want 1/0000", pre, oe);
    end
    tick();
    n_vec++;
    if (pre !== 1'b0 || oe !== 4'b0001) begin
      n_err++;
      $display("FAIL pre_next: got pre=%b oe=%b want 0/0001", pre, oe);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_vec++;
      if (oe2 !== 4'b0100 || pre2 !== 1'b0) begin
        n_err++;
        $display("FAIL nopre_hold%0d: got oe=%b pre=%b want 0100/0",
                 k, oe2, pre2);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_withdraw();
    logic seen2;
    seen2 = 1'b0;
    do_reset();
    req = 4'b0100;
    tick();
    if (oe[2]) seen2 = 1'b1;
    req = 4'b1000;
    tick();
    if (oe[2]) seen2 = 1'b1;
    n_vec++;
    if (oe !== 4'b0000 || busy !== 1'b1 || owner !== 2'd3) begin
      n_err++;
      $display("FAIL wd_turn2: got oe=%b busy=%b owner=%0d want 0000/1/3",
               oe, busy, owner);
    end
    tick();
    if (oe[2]) seen2 = 1'b1;
    n_vec++;
    if (oe !== 4'b1000) begin
      n_err++;
      $display("FAIL wd_grant: got oe=%b want 1000", oe);
    end
    n_vec++;
    if (seen2 !== 1'b0) begin
      n_err++;
      $display("FAIL wd_no_oe2: got oe2 seen=%b want 0", seen2);
    end
    req = 4'b0000;
  endtask

  task automatic test_lone();
    do_reset();
    req = 4'b0010;
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      n_vec++;
      if (oe !== 4'b0010 || pre !== 1'b0) begin
        n_err++;
        $display("FAIL lone%0d: got oe=%b pre=%b want 0010/0",
                 k, oe, pre);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_withdraw();
    test_lone();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Generates the per-driver output enables for a shared tristate bus; each `oe[i]` drives the `sel` input of one 1-bit tristate buffer stage downstream.
- Round-robin arbitration among N_REQ requesters.
- Guarantees at most one enable is high at any time.
- Inserts a fixed all-off turnaround gap before every new owner, so two drivers never contend on the bus.
- Supports optional preemption after a maximum hold time.

Parameters:
- N_REQ, 4, number of requesters / tristate drivers (2..16).
- TURNAROUND, 1, all-enables-low cycles before every grant (1..15).
- MAX_HOLD, 8, ownership cycles before forced release when another request is pending; 0 disables preemption (0..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
- req  input  N_REQ  request vector; requester i holds req[i] high for as long as it wants the bus.
- oe  output  N_REQ  one-hot-or-zero enable vector; oe[i] connects to sel of driver i.
- owner  output  $clog2(N_REQ)  index of current/pending owner; valid when busy=1.
- busy  output  1  high in TURN or OWN.
- preempt  output  1  one-cycle pulse when ownership is forcibly revoked.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE, oe=0, owner=0, busy=0, preempt=0.
  - Priority pointer ptr=0; turnaround and hold counters cleared.
  - Reset mid-ownership drops oe on that same edge.
- States: IDLE, TURN, OWN.
- Arbitration:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... with modulo N_REQ wrap.
  - Winner is latched into owner on the edge it is chosen.
- IDLE:
  - If any req is set: choose winner, go TURN, load turn counter=TURNAROUND, busy=1.
  - Otherwise stay in IDLE.
- TURN:
  - oe=0 throughout.
  - Counter decrements each cycle. At expiry, if req[owner]=1, go OWN with oe[owner]=1 and hold counter=1.
  - If req[owner] has dropped at expiry: re-arbitrate. Go TURN with the new winner (counter reloaded) if any req is set, else go IDLE with busy=0. ptr is unchanged.
  - Latency: req sampled high at edge E in IDLE → oe[owner] high from edge E+TURNAROUND.
- OWN:
  - oe[owner]=1; hold counter increments each cycle, saturating at 255.
  - Release: req[owner]=0 sampled at edge E → oe=0 from edge E; ptr=(owner+1) mod N_REQ.
  - After release: re-arbitrate with the new ptr. Go TURN if any req is set, else go IDLE.
  - Preempt: MAX_HOLD≠0, hold counter=MAX_HOLD, and any other req[j]=1 → same as release, plus preempt=1 for exactly one cycle.
  - If no other request is pending at MAX_HOLD: stay in OWN and reset the hold counter to 1.
  - Simultaneous release and preempt condition: treat as a normal release; preempt stays 0.
- Invariants:
  - popcount(oe) ≤ 1 in every cycle.
  - Between the falling oe of one owner and the rising oe of the next, exactly TURNAROUND cycles have oe=0.
  - Also true when the same requester re-wins.
- Requests changing during TURN do not alter the latched owner, except as described at TURN expiry.
- X on req during reset is ignored; X on req outside reset is not supported.

Test Plan:
- Defaults used throughout: N_REQ=4, TURNAROUND=1, MAX_HOLD=8.
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 → oe=0, busy=0, owner=0, preempt=0. Assert rst_n=0 again while oe=4'b0100 → oe=0 on the next edge.
- Single grant latency: req=4'b0010 sampled at edge E0 → busy=1 at E0. oe=4'b0010 and owner=1 from E0+1. Drop req at E5 → oe=0 and busy=0 from E5.
- Round robin with turnaround: req=4'b1011 held, each owner drops its req 3 cycles after its grant, then re-raises it. Required:
  - Grant order 0,1,3,0.
  - Exactly one oe=0 cycle between owners.
  - popcount(oe) ≤ 1 throughout.
- Preemption: req[2] held, req[0] raised while 2 owns. After 8 OE cycles of owner 2:
  - preempt=1 for one cycle and oe → 0.
  - One cycle later oe=4'b0001.
  - Repeat with MAX_HOLD=0 → owner 2 keeps the bus indefinitely.
- Request withdrawn in TURN: req=4'b0100 pulsed for one cycle with req[3] raised during TURN → no oe[2] ever. A second TURN follows, then oe=4'b1000.
- Lone owner at MAX_HOLD: only req[1] held for 20 cycles → oe=4'b0010 continuously, preempt never asserted.
